// File: rtl/vend_sched.sv
// Vending-machine sequencer: collects half/one-unit coins, requests a drink once the
// price is reached, then pays out change one half-unit coin per handshake.
module vend_sched #(
    parameter int PRICE      = 5,
    parameter int STOCK_INIT = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_money_one,
    input  logic       pi_money_half,
    input  logic       pi_cancel,
    input  logic       pi_refill,
    input  logic       disp_ack,
    input  logic       chg_ack,
    output logic       disp_req,
    output logic       chg_req,
    output logic [3:0] po_credit,
    output logic [7:0] po_stock,
    output logic       po_sold_out,
    output logic       po_reject,
    output logic       po_busy
);
    localparam logic [4:0] PRICE_HALVES = 5'(PRICE);
    localparam logic [7:0] STOCK_LOAD   = 8'(STOCK_INIT);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t     state_reg, state_next;
    logic [3:0] credit_reg, credit_next;
    logic [3:0] change_reg, change_next;
    logic [7:0] stock_reg, stock_next;
    logic       disp_req_reg, disp_req_next;
    logic       chg_req_reg, chg_req_next;
    logic       reject_reg, reject_next;
    logic       busy_reg, busy_next;
    logic       sold_out_reg;

    logic       coin_any;
    logic       accept;
    logic [4:0] coin_val;
    logic [4:0] credit_sum;

    always_comb begin
        coin_any   = pi_money_one | pi_money_half;
        accept     = (pi_money_one ^ pi_money_half)
                   && (state_reg == IDLE || state_reg == COLLECT)
                   && (stock_reg != 8'd0) && !pi_cancel;
        coin_val   = pi_money_one ? 5'd2 : 5'd1;
        credit_sum = {1'b0, credit_reg} + coin_val;

        state_next    = state_reg;
        credit_next   = credit_reg;
        change_next   = change_reg;
        stock_next    = stock_reg;
        disp_req_next = disp_req_reg;
        chg_req_next  = chg_req_reg;
        reject_next   = coin_any && !accept;

        case (state_reg)
            IDLE, COLLECT: begin
                if (accept) begin
                    // Threshold is tested from IDLE too so PRICE <= 2 cannot stall in COLLECT.
                    if (credit_sum >= PRICE_HALVES) begin
                        state_next    = VEND;
                        change_next   = 4'(credit_sum - PRICE_HALVES);
                        credit_next   = 4'd0;
                        disp_req_next = 1'b1;
                    end else begin
                        state_next  = COLLECT;
                        credit_next = credit_sum[3:0];
                    end
                end else if (state_reg == COLLECT && pi_cancel) begin
                    state_next   = CHANGE;
                    change_next  = credit_reg;
                    credit_next  = 4'd0;
                    chg_req_next = (credit_reg != 4'd0);
                end else if (state_reg == IDLE && pi_refill) begin
                    stock_next = STOCK_LOAD;
                end
            end
            VEND: begin
                if (disp_req_reg && disp_ack) begin
                    if (stock_reg != 8'd0)
                        stock_next = stock_reg - 8'd1;
                    disp_req_next = 1'b0;
                    if (change_reg != 4'd0) begin
                        state_next   = CHANGE;
                        chg_req_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CHANGE: begin
                if (change_reg == 4'd0) begin
                    state_next   = IDLE;
                    chg_req_next = 1'b0;
                end else if (chg_req_reg && chg_ack) begin
                    // Request drops for one cycle after each accepted coin.
                    change_next  = change_reg - 4'd1;
                    chg_req_next = 1'b0;
                end else begin
                    chg_req_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == VEND) || (state_next == CHANGE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg    <= IDLE;
            credit_reg   <= 4'd0;
            change_reg   <= 4'd0;
            stock_reg    <= STOCK_LOAD;
            disp_req_reg <= 1'b0;
            chg_req_reg  <= 1'b0;
            reject_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            sold_out_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            credit_reg   <= credit_next;
            change_reg   <= change_next;
            stock_reg    <= stock_next;
            disp_req_reg <= disp_req_next;
            chg_req_reg  <= chg_req_next;
            reject_reg   <= reject_next;
            busy_reg     <= busy_next;
            sold_out_reg <= (stock_reg == 8'd0);
        end
    end

    assign disp_req    = disp_req_reg;
    assign chg_req     = chg_req_reg;
    assign po_credit   = credit_reg;
    assign po_stock    = stock_reg;
    assign po_sold_out = sold_out_reg;
    assign po_reject   = reject_reg;
    assign po_busy     = busy_reg;
endmodule

// File: tb/tb_vend_sched.sv
// Directed bench for vend_sched: a default instance plus a STOCK_INIT=1 instance sharing stimulus.
module tb_vend_sched;
    logic       sys_clk = 1'b0;
    logic       sys_rst, pi_money_one, pi_money_half, pi_cancel, pi_refill, disp_ack, chg_ack;
    logic       disp_req, chg_req, po_sold_out, po_reject, po_busy;
    logic [3:0] po_credit;
    logic [7:0] po_stock;
    logic       s1_disp_req, s1_chg_req, s1_sold_out, s1_reject, s1_busy;
    logic [3:0] s1_credit;
    logic [7:0] s1_stock;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    vend_sched #(.PRICE(5), .STOCK_INIT(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .pi_money_one(pi_money_one), .pi_money_half(pi_money_half),
        .pi_cancel(pi_cancel), .pi_refill(pi_refill),
        .disp_ack(disp_ack), .chg_ack(chg_ack),
        .disp_req(disp_req), .chg_req(chg_req),
        .po_credit(po_credit), .po_stock(po_stock),
        .po_sold_out(po_sold_out), .po_reject(po_reject), .po_busy(po_busy)
    );

    vend_sched #(.PRICE(5), .STOCK_INIT(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .pi_money_one(pi_money_one), .pi_money_half(pi_money_half),
        .pi_cancel(pi_cancel), .pi_refill(pi_refill),
        .disp_ack(disp_ack), .chg_ack(chg_ack),
        .disp_req(s1_disp_req), .chg_req(s1_chg_req),
        .po_credit(s1_credit), .po_stock(s1_stock),
        .po_sold_out(s1_sold_out), .po_reject(s1_reject), .po_busy(s1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle to sample registered outputs.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic one, input logic half, input logic cancel,
                         input logic refill, input logic dack, input logic cack);
        pi_money_one = one; pi_money_half = half; pi_cancel = cancel;
        pi_refill = refill; disp_ack = dack; chg_ack = cack;
        tick();
        pi_money_one = 0; pi_money_half = 0; pi_cancel = 0;
        pi_refill = 0; disp_ack = 0; chg_ack = 0;
    endtask

    initial begin
        sys_rst = 1; pi_money_one = 0; pi_money_half = 0; pi_cancel = 0;
        pi_refill = 0; disp_ack = 0; chg_ack = 0;
        tick(); tick();
        sys_rst = 0;
        chk("rst_credit", po_credit, 0);
        chk("rst_stock", po_stock, 8);
        chk("rst_stock_s1", s1_stock, 1);
        chk("rst_busy", po_busy, 0);
        chk("rst_disp", disp_req, 0);
        chk("rst_sold", po_sold_out, 0);

        // one, one, half -> exact price, no change
        pulse(1,0,0,0,0,0); chk("a_credit2", po_credit, 2); chk("a_rej0", po_reject, 0);
        pulse(1,0,0,0,0,0); chk("a_credit4", po_credit, 4);
        pulse(0,1,0,0,0,0);
        chk("a_vend_credit", po_credit, 0); chk("a_disp1", disp_req, 1); chk("a_busy1", po_busy, 1);
        tick(); chk("a_disp_hold", disp_req, 1); chk("a_stock_hold", po_stock, 8);
        pulse(0,0,0,0,1,0);
        chk("a_stock7", po_stock, 7); chk("a_disp0", disp_req, 0);
        chk("a_busy0", po_busy, 0); chk("a_chg0", chg_req, 0);
        chk("a_s1_stock0", s1_stock, 0); chk("a_s1_sold_lag", s1_sold_out, 0);
        tick(); chk("a_s1_sold1", s1_sold_out, 1); chk("a_sold0", po_sold_out, 0);

        // sold-out instance refuses the next coin
        pulse(0,1,0,0,0,0);
        chk("b_s1_rej", s1_reject, 1); chk("b_s1_credit", s1_credit, 0);
        chk("b_credit1", po_credit, 1); chk("b_rej0", po_reject, 0);
        tick(); chk("b_s1_rej_drop", s1_reject, 0);
        pulse(0,0,1,0,0,0);
        chk("b_cancel_chg", chg_req, 1); chk("b_cancel_credit", po_credit, 0); chk("b_cancel_busy", po_busy, 1);
        pulse(0,0,0,0,0,1); chk("b_chg_drop", chg_req, 0);
        tick(); chk("b_idle_busy", po_busy, 0); chk("b_idle_chg", chg_req, 0);
        pulse(0,0,0,1,0,0);
        chk("b_refill", po_stock, 8); chk("b_s1_refill", s1_stock, 1); chk("b_s1_sold_lag", s1_sold_out, 1);
        tick(); chk("b_s1_sold0", s1_sold_out, 0);

        // half, one, one -> 5 exact
        pulse(0,1,0,0,0,0); pulse(1,0,0,0,0,0); pulse(1,0,0,0,0,0);
        chk("c_disp1", disp_req, 1); chk("c_credit0", po_credit, 0);
        pulse(0,0,0,0,1,0); chk("c_stock7", po_stock, 7); chk("c_chg0", chg_req, 0); chk("c_busy0", po_busy, 0);
        // one, one, one -> credit 6, one change coin
        pulse(1,0,0,0,0,0); pulse(1,0,0,0,0,0); chk("c_credit4", po_credit, 4);
        pulse(1,0,0,0,0,0); chk("c_disp_b", disp_req, 1); chk("c_credit_clr", po_credit, 0);
        pulse(0,0,0,0,1,0);
        chk("c_stock6", po_stock, 6); chk("c_chg1", chg_req, 1); chk("c_disp_drop", disp_req, 0);
        pulse(0,0,0,0,0,1); chk("c_chg_drop", chg_req, 0); chk("c_busy_chg", po_busy, 1);
        tick(); chk("c_done_busy", po_busy, 0); chk("c_done_chg", chg_req, 0);

        // one, half, cancel -> three change coins; ack in the low cycle is ignored
        pulse(1,0,0,0,0,0); pulse(0,1,0,0,0,0); chk("d_credit3", po_credit, 3);
        pulse(0,0,1,0,0,0); chk("d_chg1", chg_req, 1); chk("d_credit0", po_credit, 0);
        chg_ack = 1; tick(); chk("d_h1_low", chg_req, 0);
        tick(); chg_ack = 0; chk("d_ignored_ack", chg_req, 1);
        pulse(0,0,0,0,0,1); chk("d_h2_low", chg_req, 0);
        tick(); chk("d_h3_req", chg_req, 1);
        pulse(0,0,0,0,0,1); chk("d_h3_low", chg_req, 0); chk("d_h3_busy", po_busy, 1);
        tick(); chk("d_idle", po_busy, 0); chk("d_no_req", chg_req, 0);
        chk("d_no_disp", disp_req, 0); chk("d_stock6", po_stock, 6);

        // both coins in COLLECT, coin during VEND, cancel in IDLE
        pulse(0,0,1,0,0,0); chk("e_cancel_idle_busy", po_busy, 0); chk("e_cancel_idle_chg", chg_req, 0);
        pulse(1,0,0,0,0,0); chk("e_credit2", po_credit, 2);
        pulse(1,1,0,0,0,0); chk("e_both_rej", po_reject, 1); chk("e_both_credit", po_credit, 2);
        tick(); chk("e_rej_pulse", po_reject, 0);
        pulse(1,0,0,0,0,0); pulse(0,1,0,0,0,0); chk("e_vend", disp_req, 1);
        pulse(1,0,0,0,0,0); chk("e_vend_rej", po_reject, 1); chk("e_vend_credit", po_credit, 0);
        chk("e_vend_disp", disp_req, 1);
        pulse(0,0,0,0,1,0); chk("e_stock5", po_stock, 5); chk("e_idle", po_busy, 0);

        // reset mid-change wins over a coliding coin
        pulse(1,0,0,0,0,0); pulse(0,1,0,0,0,0); pulse(0,0,1,0,0,0);
        chk("f_chg_req", chg_req, 1);
        sys_rst = 1; pi_money_one = 1; tick(); sys_rst = 0; pi_money_one = 0;
        chk("f_chg0", chg_req, 0); chk("f_busy0", po_busy, 0); chk("f_credit0", po_credit, 0);
        chk("f_stock8", po_stock, 8); chk("f_rej0", po_reject, 0);
        tick(); chk("f_stays_idle", chg_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
